// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
//   Fetch stage for the instruction ROM. Owns the PC and drives the ROM
//   address. Each fetched word is registered, together with its PC, into a
//   one-entry output slot that decode drains over a valid/ready handshake.
//   A redirect (branch/jump) reloads the PC and flushes the slot. Enable
//   pauses fetching, but the slot can still drain while the stage is paused.
//
// Ports
//   i_Clk          clock, rising edge
//   i_Rst_n        asynchronous active-low reset
//   o_Addr         ROM address (= PC); the ROM indexes o_Addr[9:2]
//   i_Inst         ROM data for o_Addr, valid in the same cycle
//   i_Enable       1 = allow fetching
//   i_Redirect     1 = load PC from i_RedirectPC and flush the slot
//   i_RedirectPC   redirect target
//   o_OutValid     slot holds a valid instruction
//   i_OutReady     decode accepts the slot this cycle
//   o_OutInst      slot instruction
//   o_OutPC        PC of o_OutInst
//   o_OutPCPlus4   o_OutPC + 4 (modulo 2^32)
//   o_Misalign     sticky flag: some redirect target was not word aligned
//   o_FetchCount   number of fetches (only counts when FETCH_CNT_EN is defined)
//
// Configuration macro
//   FETCH_CNT_EN   when defined, a 32-bit fetch counter is built; otherwise
//                  o_FetchCount is tied to zero.
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  output logic [31:0] o_Addr,
  input  logic [31:0] i_Inst,
  input  logic        i_Enable,
  input  logic        i_Redirect,
  input  logic [31:0] i_RedirectPC,
  output logic        o_OutValid,
  input  logic        i_OutReady,
  output logic [31:0] o_OutInst,
  output logic [31:0] o_OutPC,
  output logic [31:0] o_OutPCPlus4,
  output logic        o_Misalign,
  output logic [31:0] o_FetchCount
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    IDLE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_pc;
  logic        r_outValid;
  logic [31:0] r_outInst;
  logic [31:0] r_outPC;
  logic        r_misalign;
  logic        w_take;
  logic        w_fire;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // BOOT spends one cycle without fetching; afterwards Enable alone decides
  // between RUN and IDLE. A redirect never changes the state transition.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      BOOT:    w_nextState = i_Enable ? RUN : IDLE;
      RUN:     if (!i_Enable) w_nextState = IDLE;
      IDLE:    if (i_Enable) w_nextState = RUN;
      default: w_nextState = BOOT;
    endcase
  end

  // A fetch may only overwrite the slot when it is empty or being consumed
  // in the same cycle, so nothing is lost under backpressure.
  assign w_take = r_outValid & i_OutReady;
  assign w_fire = (r_state == RUN) & i_Enable & ~i_Redirect
                & (~r_outValid | i_OutReady);

  // Redirect has priority over fetch and over a plain take: the slot is
  // flushed even if decode is taking the old word that cycle.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_pc       <= RESET_PC;
      r_outValid <= 1'b0;
      r_outInst  <= 32'h0;
      r_outPC    <= 32'h0;
      r_misalign <= 1'b0;
    end else begin
      if (i_Redirect) begin
        r_pc       <= {i_RedirectPC[31:2], 2'b00};
        r_outValid <= 1'b0;
      end else if (w_fire) begin
        r_outInst  <= i_Inst;
        r_outPC    <= r_pc;
        r_outValid <= 1'b1;
        r_pc       <= r_pc + 32'd4;
      end else if (w_take) begin
        r_outValid <= 1'b0;
      end
      if (i_Redirect && (i_RedirectPC[1:0] != 2'b00)) begin
        r_misalign <= 1'b1;
      end
    end
  end

`ifdef FETCH_CNT_EN
  logic [31:0] r_fetchCount;

  // Counts every fire; a redirect does not clear it, and it wraps naturally.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_fetchCount <= 32'h0;
    end else if (w_fire) begin
      r_fetchCount <= r_fetchCount + 32'd1;
    end
  end

  assign o_FetchCount = r_fetchCount;
`else
  assign o_FetchCount = 32'h0;
`endif

  assign o_Addr       = r_pc;
  assign o_OutValid   = r_outValid;
  assign o_OutInst    = r_outInst;
  assign o_OutPC      = r_outPC;
  assign o_OutPCPlus4 = r_outPC + 32'd4;
  assign o_Misalign   = r_misalign;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_unit
//   Self-checking bench for inst_fetch_unit. A small ROM model answers the
//   fetch address combinationally. A table of per-cycle vectors walks through
//   the directed fetch, backpressure, redirect, misalign, wrap and drain
//   sequences; a hand-written sequence drops reset mid-backpressure; a
//   randomized phase is checked against a cycle-level reference model.
// ---------------------------------------------------------------------------
module tb_inst_fetch_unit;

`ifdef FETCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        enable;
  logic        redirect;
  logic [31:0] redirectPC;
  logic        outValid;
  logic        outReady;
  logic [31:0] outInst;
  logic [31:0] outPC;
  logic [31:0] outPCPlus4;
  logic        misalign;
  logic [31:0] fetchCount;

  logic [31:0] rom [256];
  int          nCompared;
  int          nMismatched;

  inst_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .o_Addr       (addr),
    .i_Inst       (inst),
    .i_Enable     (enable),
    .i_Redirect   (redirect),
    .i_RedirectPC (redirectPC),
    .o_OutValid   (outValid),
    .i_OutReady   (outReady),
    .o_OutInst    (outInst),
    .o_OutPC      (outPC),
    .o_OutPCPlus4 (outPCPlus4),
    .o_Misalign   (misalign),
    .o_FetchCount (fetchCount)
  );

  assign inst = rom[addr[9:2]];

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        expValid;
    logic [31:0] expPC;
    logic [31:0] expInst;
    logic [31:0] expAddr;
    logic        expMis;
    logic [31:0] expCnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic en, logic rdy, logic redir, logic [31:0] rpc,
                              logic v, logic [31:0] pc, logic [31:0] ins,
                              logic [31:0] a, logic mis, logic [31:0] cnt);
    vec_t r;
    r.en = en; r.rdy = rdy; r.redir = redir; r.rpc = rpc;
    r.expValid = v; r.expPC = pc; r.expInst = ins; r.expAddr = a;
    r.expMis = mis; r.expCnt = cnt;
    return r;
  endfunction

  // Drive one cycle's worth of inputs.
  task automatic applyStimulus(input logic en, input logic rdy,
                               input logic redir, input logic [31:0] rpc);
    enable     = en;
    outReady   = rdy;
    redirect   = redir;
    redirectPC = rpc;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model state: tracks fetch behaviour in terms of "was the stage
  // enabled at the previous edge" rather than an explicit state machine.
  bit          mEnabledLast;
  logic [31:0] mPc;
  bit          mValid;
  logic [31:0] mSlotInst;
  logic [31:0] mSlotPc;
  bit          mMis;
  logic [31:0] mCount;

  task automatic modelReset();
    mEnabledLast = 0;
    mPc = 32'h0; mValid = 0; mSlotInst = 32'h0; mSlotPc = 32'h0;
    mMis = 0; mCount = 32'h0;
  endtask

  task automatic modelStep(input logic en, input logic rdy,
                           input logic redir, input logic [31:0] rpc);
    bit canFetch;
    canFetch = mEnabledLast && en && !redir && (!mValid || rdy);
    if (redir) begin
      if (rpc % 4 != 0) mMis = 1;
      mPc = rpc - (rpc % 4);
      mValid = 0;
    end else if (canFetch) begin
      mSlotInst = rom[(mPc / 4) % 256];
      mSlotPc = mPc;
      mValid = 1;
      mPc = mPc + 4;
      mCount = mCount + 1;
    end else if (mValid && rdy) begin
      mValid = 0;
    end
    mEnabledLast = en;
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
    rom[0] = 32'h34010005;
    rom[1] = 32'h34020003;
    rom[2] = 32'h00221820;
    rom[3] = 32'h00232022;
    rom[4] = 32'h0044282A;

    // Directed table: each row is one clock cycle, checked just after the edge.
    vecs.push_back(mk(1,1,0,0,           0,0,0,32'h0,0,0));
    vecs.push_back(mk(1,1,0,0,           1,32'h0,32'h34010005,32'h4,0,1));
    vecs.push_back(mk(1,1,0,0,           1,32'h4,32'h34020003,32'h8,0,2));
    vecs.push_back(mk(1,1,0,0,           1,32'h8,32'h00221820,32'hC,0,3));
    vecs.push_back(mk(1,1,0,0,           1,32'hC,32'h00232022,32'h10,0,4));
    vecs.push_back(mk(1,1,0,0,           1,32'h10,32'h0044282A,32'h14,0,5));
    vecs.push_back(mk(1,1,1,32'h4,       0,0,0,32'h4,0,5));
    vecs.push_back(mk(1,1,0,0,           1,32'h4,32'h34020003,32'h8,0,6));
    vecs.push_back(mk(1,0,0,0,           1,32'h4,32'h34020003,32'h8,0,6));
    vecs.push_back(mk(1,0,0,0,           1,32'h4,32'h34020003,32'h8,0,6));
    vecs.push_back(mk(1,0,0,0,           1,32'h4,32'h34020003,32'h8,0,6));
    vecs.push_back(mk(1,1,0,0,           1,32'h8,32'h00221820,32'hC,0,7));
    vecs.push_back(mk(1,1,1,32'h10,      0,0,0,32'h10,0,7));
    vecs.push_back(mk(1,1,0,0,           1,32'h10,32'h0044282A,32'h14,0,8));
    vecs.push_back(mk(1,1,1,32'h13,      0,0,0,32'h10,1,8));
    vecs.push_back(mk(1,1,1,32'h8,       0,0,0,32'h8,1,8));
    vecs.push_back(mk(1,1,0,0,           1,32'h8,32'h00221820,32'hC,1,9));
    vecs.push_back(mk(1,1,1,32'hFFFFFFFC,0,0,0,32'hFFFFFFFC,1,9));
    vecs.push_back(mk(1,1,0,0,           1,32'hFFFFFFFC,32'h0,32'h0,1,10));
    vecs.push_back(mk(0,0,0,0,           1,32'hFFFFFFFC,32'h0,32'h0,1,10));
    vecs.push_back(mk(0,1,0,0,           0,0,0,32'h0,1,10));
    vecs.push_back(mk(0,1,0,0,           0,0,0,32'h0,1,10));

    // Reset state, checked before any clock edge.
    rst_n = 1'b0;
    applyStimulus(1, 1, 0, 32'h0);
    #3;
    checkOutput("reset valid", {31'h0, outValid}, 32'h0);
    checkOutput("reset addr", addr, 32'h0);
    checkOutput("reset inst", outInst, 32'h0);
    checkOutput("reset pc", outPC, 32'h0);
    checkOutput("reset misalign", {31'h0, misalign}, 32'h0);
    checkOutput("reset count", fetchCount, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].en, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d valid", i), {31'h0, outValid}, {31'h0, vecs[i].expValid});
      checkOutput($sformatf("vec%0d addr", i), addr, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d misalign", i), {31'h0, misalign}, {31'h0, vecs[i].expMis});
      checkOutput($sformatf("vec%0d count", i), fetchCount, CNT_EN ? vecs[i].expCnt : 32'h0);
      if (vecs[i].expValid) begin
        checkOutput($sformatf("vec%0d pc", i), outPC, vecs[i].expPC);
        checkOutput($sformatf("vec%0d inst", i), outInst, vecs[i].expInst);
        checkOutput($sformatf("vec%0d pcplus4", i), outPCPlus4, vecs[i].expPC + 32'd4);
      end
    end

    // Reset dropped while the slot is stalled by backpressure.
    applyStimulus(1, 0, 0, 32'h0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("stall valid", {31'h0, outValid}, 32'h1);
    checkOutput("stall addr", addr, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset valid", {31'h0, outValid}, 32'h0);
    checkOutput("async reset addr", addr, 32'h0);
    checkOutput("async reset inst", outInst, 32'h0);
    checkOutput("async reset misalign", {31'h0, misalign}, 32'h0);
    checkOutput("async reset count", fetchCount, 32'h0);

    // Randomized phase against the reference model, with a random ROM.
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    modelReset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic        en, rdy, redir;
      logic [31:0] rpc;
      en    = ($urandom_range(0, 99) < 85);
      rdy   = ($urandom_range(0, 99) < 70);
      redir = ($urandom_range(0, 99) < 6);
      rpc   = $urandom;
      if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
      applyStimulus(en, rdy, redir, rpc);
      modelStep(en, rdy, redir, rpc);
      @(posedge clk); #1;
      checkOutput($sformatf("rnd%0d valid", c), {31'h0, outValid}, {31'h0, mValid});
      checkOutput($sformatf("rnd%0d addr", c), addr, mPc);
      checkOutput($sformatf("rnd%0d misalign", c), {31'h0, misalign}, {31'h0, mMis});
      checkOutput($sformatf("rnd%0d count", c), fetchCount, CNT_EN ? mCount : 32'h0);
      if (mValid) begin
        checkOutput($sformatf("rnd%0d pc", c), outPC, mSlotPc);
        checkOutput($sformatf("rnd%0d inst", c), outInst, mSlotInst);
        checkOutput($sformatf("rnd%0d pcplus4", c), outPCPlus4, mSlotPc + 32'd4);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
